// File: rtl/perceptron_if.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron_if
//  Description : Bundle of the data/control signals exchanged between a
//                perceptron neuron and its surrounding layer logic. All
//                arithmetic values are signed Q16.16 carried as 32-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
interface perceptron_if #(
    parameter int IN_UNITS  = 2,
    parameter int OUT_UNITS = 1
);
    logic [IN_UNITS-1:0][31:0]  values_i;
    logic [1:0]                 activation_i;   // 0 Linear, 1 ReLU, 2 Sigmoid
    logic                       training_i;
    logic [31:0]                learning_rate_i;
    logic [OUT_UNITS-1:0][31:0] next_layer_weights_i;
    logic [OUT_UNITS-1:0][31:0] error_gradient_next_layer_i;
    logic [31:0]                prediction_o;
    logic [31:0]                error_gradient_o;
    logic [IN_UNITS-1:0][31:0]  current_weights_o;

    // Layer side: drives activations and feedback, observes the neuron.
    modport master (
        output values_i, activation_i, training_i, learning_rate_i,
               next_layer_weights_i, error_gradient_next_layer_i,
        input  prediction_o, error_gradient_o, current_weights_o
    );

    // Neuron side.
    modport slave (
        input  values_i, activation_i, training_i, learning_rate_i,
               next_layer_weights_i, error_gradient_next_layer_i,
        output prediction_o, error_gradient_o, current_weights_o
    );
endinterface
`default_nettype wire

// File: rtl/perceptron.sv
`default_nettype none
// ============================================================================
//  Module      : perceptron
//  Description : Single trainable neuron in signed Q16.16. Registers the
//                weighted sum plus bias and its activation, exposes its
//                backpropagated delta and weights, and applies one SGD step
//                per clock while training. All arithmetic saturates.
//  Revision    : 1.0 - initial release
// ============================================================================
module perceptron #(
    parameter int                 INPUT_UNITS  = 2,
    parameter int                 OUTPUT_UNITS = 1,
    parameter logic signed [31:0] INIT_WEIGHT  = 32'sh0000_8000
) (
    input  wire logic clk,
    input  wire logic rst,
    perceptron_if.slave bus
);

    localparam logic signed [63:0] c_MAX64 = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] c_MIN64 = 64'shFFFF_FFFF_8000_0000;
    localparam logic signed [31:0] c_MAX32 = 32'sh7FFF_FFFF;
    localparam logic signed [31:0] c_MIN32 = 32'sh8000_0000;
    localparam logic signed [31:0] c_ZERO  = 32'sh0000_0000;
    localparam logic signed [31:0] c_ONE   = 32'sh0001_0000;
    localparam logic signed [31:0] c_HALF  = 32'sh0000_8000;
    // Sigmoid breakpoints and offsets (PLAN approximation)
    localparam logic signed [31:0] c_SIG_A5    = 32'sh0005_0000;  // 5.0
    localparam logic signed [31:0] c_SIG_A2375 = 32'sh0002_6000;  // 2.375
    localparam logic signed [31:0] c_SIG_OFF2  = 32'sh0000_D800;  // 0.84375
    localparam logic signed [31:0] c_SIG_OFF1  = 32'sh0000_A000;  // 0.625

    localparam logic [1:0] c_ACT_LINEAR  = 2'd0;
    localparam logic [1:0] c_ACT_RELU    = 2'd1;
    localparam logic [1:0] c_ACT_SIGMOID = 2'd2;

    // ------------------------------------------------------------------
    // Saturating Q16.16 helpers
    // ------------------------------------------------------------------
    function automatic logic signed [31:0] f_sat(input logic signed [63:0] v);
        if (v > c_MAX64)      return c_MAX32;
        else if (v < c_MIN64) return c_MIN32;
        else                  return $signed(v[31:0]);
    endfunction

    function automatic logic signed [31:0] f_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        return f_sat(64'(a) + 64'(b));
    endfunction

    function automatic logic signed [31:0] f_sub(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        return f_sat(64'(a) - 64'(b));
    endfunction

    function automatic logic signed [31:0] f_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return f_sat(p >>> 16);
    endfunction

    // Piecewise-linear sigmoid evaluated on |z|, mirrored for negative z.
    // |MIN| saturates to MAX, which lands in the flat top segment anyway.
    function automatic logic signed [31:0] f_sigmoid(input logic signed [31:0] z);
        logic signed [31:0] a;
        logic signed [31:0] f;
        a = (z < c_ZERO) ? f_sub(c_ZERO, z) : z;
        if (a >= c_SIG_A5)         f = c_ONE;
        else if (a >= c_SIG_A2375) f = (a >>> 5) + c_SIG_OFF2;
        else if (a >= c_ONE)       f = (a >>> 3) + c_SIG_OFF1;
        else                       f = (a >>> 2) + c_HALF;
        return (z < c_ZERO) ? (c_ONE - f) : f;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [31:0] weight_q [INPUT_UNITS];
    logic signed [31:0] weight_d [INPUT_UNITS];
    logic signed [31:0] x_q      [INPUT_UNITS];
    logic signed [31:0] x_d      [INPUT_UNITS];
    logic signed [31:0] bias_q, bias_d;
    logic signed [31:0] z_q,    z_d;
    logic signed [31:0] pred_q, pred_d;

    logic signed [31:0] w_fwd_acc;
    logic signed [31:0] w_z;
    logic signed [31:0] w_act;
    logic signed [31:0] w_grad_sum;
    logic signed [31:0] w_deriv;
    logic signed [31:0] w_delta;
    logic signed [31:0] w_step;

    // Forward sum in index order against the weights held before this edge.
    always_comb begin
        w_fwd_acc = c_ZERO;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            w_fwd_acc = f_add(w_fwd_acc, f_mul(weight_q[i], $signed(bus.values_i[i])));
        end
        w_z = f_add(w_fwd_acc, bias_q);
    end

    // Activation of the fresh sum; unused select code falls back to linear.
    always_comb begin
        w_act = w_z;
        case (bus.activation_i)
            c_ACT_RELU:    w_act = (w_z > c_ZERO) ? w_z : c_ZERO;
            c_ACT_SIGMOID: w_act = f_sigmoid(w_z);
            default:       w_act = w_z;
        endcase
    end

    // Delta: downstream gradient sum scaled by act' of the registered state.
    always_comb begin
        w_grad_sum = c_ZERO;
        for (int k = 0; k < OUTPUT_UNITS; k++) begin
            w_grad_sum = f_add(w_grad_sum,
                               f_mul($signed(bus.next_layer_weights_i[k]),
                                     $signed(bus.error_gradient_next_layer_i[k])));
        end
        w_deriv = c_ONE;
        case (bus.activation_i)
            c_ACT_RELU:    w_deriv = (z_q > c_ZERO) ? c_ONE : c_ZERO;
            c_ACT_SIGMOID: w_deriv = f_mul(pred_q, f_sub(c_ONE, pred_q));
            default:       w_deriv = c_ONE;
        endcase
        w_delta = f_mul(w_grad_sum, w_deriv);
    end

    // Next state: SGD step ((lr*delta)*x) when training, forward registers always.
    always_comb begin
        w_step = f_mul($signed(bus.learning_rate_i), w_delta);
        bias_d = bias_q;
        for (int i = 0; i < INPUT_UNITS; i++) begin
            weight_d[i] = weight_q[i];
            x_d[i]      = $signed(bus.values_i[i]);
        end
        if (bus.training_i) begin
            bias_d = f_sub(bias_q, w_step);
            for (int i = 0; i < INPUT_UNITS; i++) begin
                weight_d[i] = f_sub(weight_q[i], f_mul(w_step, x_q[i]));
            end
        end
        z_d    = w_z;
        pred_d = w_act;
    end

    // State register; reset wins over any pending update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < INPUT_UNITS; i++) begin
                weight_q[i] <= INIT_WEIGHT;
                x_q[i]      <= c_ZERO;
            end
            bias_q <= c_ZERO;
            z_q    <= c_ZERO;
            pred_q <= c_ZERO;
        end else begin
            for (int i = 0; i < INPUT_UNITS; i++) begin
                weight_q[i] <= weight_d[i];
                x_q[i]      <= x_d[i];
            end
            bias_q <= bias_d;
            z_q    <= z_d;
            pred_q <= pred_d;
        end
    end

    assign bus.prediction_o     = pred_q;
    assign bus.error_gradient_o = w_delta;

    generate
        for (genvar gi = 0; gi < INPUT_UNITS; gi++) begin : g_cw
            assign bus.current_weights_o[gi] = weight_q[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_perceptron.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perceptron
//  Description : Self-checking bench for perceptron. A longint reference
//                model tracks weights, bias and registered state; every
//                negedge the outputs are compared with it. Directed cases
//                pin the model with hand-computed literals, then a random
//                phase exercises all activations, training and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perceptron;

    localparam int    NI   = 2;
    localparam int    NO   = 1;
    localparam longint ONE = 65536;
    localparam longint HALF = 32768;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    perceptron_if #(.IN_UNITS(NI), .OUT_UNITS(NO)) bus ();

    perceptron #(.INPUT_UNITS(NI), .OUTPUT_UNITS(NO), .INIT_WEIGHT(32'sh0000_8000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint m_w [NI];
    longint m_x [NI];
    longint m_b, m_z, m_p;
    bit     model_ok = 1'b0;

    function automatic longint clamp(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    function automatic longint mul(input longint a, input longint b);
        return clamp((a * b) >>> 16);
    endfunction

    function automatic longint sx(input logic [31:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sigm(input longint z);
        longint a, f;
        a = (z < 0) ? clamp(-z) : z;
        if (a >= 5 * ONE)       f = ONE;
        else if (a >= 155648)   f = a / 32 + 55296;   // 2.375 and 27/32
        else if (a >= ONE)      f = a / 8 + 40960;    // 0.625
        else                    f = a / 4 + HALF;
        return (z < 0) ? ONE - f : f;
    endfunction

    function automatic longint act(input longint z, input int sel);
        if (sel == 1) return (z > 0) ? z : 0;
        if (sel == 2) return sigm(z);
        return z;
    endfunction

    function automatic longint model_delta();
        longint g, d;
        int     sel;
        g = 0;
        for (int k = 0; k < NO; k++)
            g = clamp(g + mul(sx(bus.next_layer_weights_i[k]), sx(bus.error_gradient_next_layer_i[k])));
        sel = int'(bus.activation_i);
        if (sel == 1)      d = (m_z > 0) ? ONE : 0;
        else if (sel == 2) d = mul(m_p, ONE - m_p);
        else               d = ONE;
        return mul(g, d);
    endfunction

    // Model state update on every clock edge.
    always @(posedge clk) begin
        longint z, st;
        if (rst) begin
            for (int i = 0; i < NI; i++) begin
                m_w[i] <= 32768;
                m_x[i] <= 0;
            end
            m_b <= 0; m_z <= 0; m_p <= 0;
            model_ok <= 1'b1;
        end else if (model_ok) begin
            z = 0;
            for (int i = 0; i < NI; i++) z = clamp(z + mul(m_w[i], sx(bus.values_i[i])));
            z = clamp(z + m_b);
            if (bus.training_i) begin
                st = mul(sx(bus.learning_rate_i), model_delta());
                for (int i = 0; i < NI; i++) m_w[i] <= clamp(m_w[i] - mul(st, m_x[i]));
                m_b <= clamp(m_b - st);
            end
            for (int i = 0; i < NI; i++) m_x[i] <= sx(bus.values_i[i]);
            m_z <= z;
            m_p <= act(z, int'(bus.activation_i));
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, got, got[31:0], exp, exp[31:0], $time);
        end
    endtask

    // Continuous compare against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_prediction", sx(bus.prediction_o), m_p);
            chk("model_error_gradient", sx(bus.error_gradient_o), model_delta());
            for (int i = 0; i < NI; i++)
                chk("model_weight", sx(bus.current_weights_o[i]), m_w[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vals(input longint a, input longint b);
        bus.values_i[0] = a[31:0];
        bus.values_i[1] = b[31:0];
    endtask

    function automatic logic [31:0] rnd_val(input int span);
        int r;
        if ($urandom_range(0, 7) == 0) return $urandom;
        r = int'($urandom_range(0, 2 * span)) - span;
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        set_vals(ONE, ONE);
        bus.activation_i                   = 2'd0;
        bus.training_i                     = 1'b0;
        bus.learning_rate_i                = 32'h0;
        bus.next_layer_weights_i[0]        = 32'h0;
        bus.error_gradient_next_layer_i[0] = 32'h0;

        // Reset and hold
        cyc(); cyc(); #1;
        chk("rst_w0", sx(bus.current_weights_o[0]), 32768);
        chk("rst_w1", sx(bus.current_weights_o[1]), 32768);
        chk("rst_pred", sx(bus.prediction_o), 0);
        rst = 1'b0;
        cyc(); #1;
        chk("lin_pred", sx(bus.prediction_o), 32'h0001_0000);
        cyc(); #1;
        chk("lin_hold", sx(bus.prediction_o), 32'h0001_0000);

        // Sigmoid points
        bus.activation_i = 2'd2;
        set_vals(0, 0);
        cyc(); #1;
        chk("sig_z0", sx(bus.prediction_o), 32'h0000_8000);
        set_vals(ONE, ONE);
        cyc(); #1;
        chk("sig_z1", sx(bus.prediction_o), 32'h0000_C000);
        set_vals(-4 * ONE, -4 * ONE);
        cyc(); #1;
        chk("sig_zm4", sx(bus.prediction_o), 32'h0000_0800);

        // Linear SGD step
        rst = 1'b1;
        bus.activation_i                   = 2'd0;
        set_vals(ONE, 0);
        bus.next_layer_weights_i[0]        = 32'h0001_0000;
        bus.error_gradient_next_layer_i[0] = 32'h0000_8000;
        bus.learning_rate_i                = 32'h0001_0000;
        cyc();
        rst = 1'b0;
        cyc();
        bus.training_i = 1'b1;
        #1;
        chk("sgd_delta", sx(bus.error_gradient_o), 32'h0000_8000);
        cyc();
        bus.training_i = 1'b0;
        #1;
        chk("sgd_w0", sx(bus.current_weights_o[0]), 0);
        chk("sgd_w1", sx(bus.current_weights_o[1]), 32'h0000_8000);
        chk("sgd_pred_pre", sx(bus.prediction_o), 32'h0000_8000);
        cyc(); #1;
        chk("sgd_pred_post", sx(bus.prediction_o), -32768);

        // ReLU dead zone
        rst = 1'b1;
        bus.activation_i = 2'd1;
        set_vals(-ONE, -ONE);
        bus.training_i = 1'b1;
        cyc();
        rst = 1'b0;
        cyc(); #1;
        chk("relu_pred", sx(bus.prediction_o), 0);
        chk("relu_delta", sx(bus.error_gradient_o), 0);
        cyc(); #1;
        chk("relu_w0", sx(bus.current_weights_o[0]), 32768);
        chk("relu_w1", sx(bus.current_weights_o[1]), 32768);

        // Saturation: grow weights to 1.5 and bias to 1.0, then drive extremes
        rst = 1'b1;
        bus.activation_i = 2'd0;
        bus.training_i   = 1'b0;
        set_vals(ONE, ONE);
        bus.error_gradient_next_layer_i[0] = 32'hFFFF_0000;
        cyc();
        rst = 1'b0;
        cyc();
        bus.training_i = 1'b1;
        cyc();
        bus.training_i = 1'b0;
        set_vals(MAXV, MAXV);
        #1;
        chk("sat_w0", sx(bus.current_weights_o[0]), 32'h0001_8000);
        cyc(); #1;
        chk("sat_pos", sx(bus.prediction_o), 32'sh7FFF_FFFF);
        set_vals(MINV, MINV);
        cyc(); #1;
        chk("sat_neg", sx(bus.prediction_o), 32'sh8001_0000);

        // Reset in the middle of a training update
        bus.training_i = 1'b1;
        rst = 1'b1;
        cyc(); #1;
        chk("rstmid_w0", sx(bus.current_weights_o[0]), 32768);
        chk("rstmid_w1", sx(bus.current_weights_o[1]), 32768);
        chk("rstmid_pred", sx(bus.prediction_o), 0);
        rst = 1'b0;
        bus.training_i = 1'b0;

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst                                = ($urandom_range(0, 99) == 0);
            bus.activation_i                   = 2'($urandom_range(0, 2));
            bus.training_i                     = 1'($urandom_range(0, 1));
            bus.learning_rate_i                = $urandom_range(0, 32768);
            bus.values_i[0]                    = rnd_val(262144);
            bus.values_i[1]                    = rnd_val(262144);
            bus.next_layer_weights_i[0]        = rnd_val(131072);
            bus.error_gradient_next_layer_i[0] = rnd_val(131072);
        end
        cyc();
        @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/perceptron.md
Name: perceptron

Overview:
- Single trainable neuron for the fixed-point MLP datapath (sfp = signed Q16.16, 32-bit, from FixedPoint; ONE = 0x0001_0000, HALF = 0x0000_8000).
- Computes a weighted sum plus bias of `input_units` inputs and applies a selectable activation.
- Exposes its backpropagated error gradient (delta) and weights to neighbouring layers.
- When training, performs one SGD update per clock using the downstream layer's weights and gradients.

Parameters:
- input_units, default 2, number of inputs and weights.
- output_units, default 1, number of downstream neurons feeding back gradients.
- INIT_WEIGHT, default 0x0000_8000 (0.5), reset value of every weight; bias resets to 0.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- values  in  sfp[input_units]  input activations x_i.
- activation  in  act_func (Common enum: Linear, ReLU, Sigmoid)  activation select.
- training  in  1  enables the weight/bias update.
- learning_rate  in  sfp  SGD step size lr.
- next_layer_weights  in  sfp[output_units]  this neuron's weight in each downstream neuron.
- error_gradient_next_layer  in  sfp[output_units]  downstream deltas.
- prediction  out  sfp  registered activation output.
- error_gradient  out  sfp  this neuron's delta (combinational from registered state and inputs).
- current_weights  out  sfp[input_units]  current weight registers.

Behaviour:
- Arithmetic:
  - Multiply is a 64-bit signed product, arithmetic shift right 16, saturated to 32-bit signed.
  - Add and subtract saturate to [0x8000_0000, 0x7FFF_FFFF].
  - Sums accumulate in index order with saturation at each step.
- Reset (rst=1 at posedge):
  - w_i = INIT_WEIGHT, bias = 0.
  - x_q = 0, z_q = 0, prediction = 0.
  - No update occurs in a reset cycle, and reset overrides training.
- Forward path, every non-reset posedge:
  - z = sum(w_i*values_i) + bias, computed with the weights held before this edge.
  - z_q <= z; x_q <= values; prediction <= act(z).
  - Latency: values applied before edge N appear in prediction after edge N (1 cycle).
- Activations:
  - Linear: act(z) = z, act'(z) = ONE.
  - ReLU: act(z) = (z>0) ? z : 0, act'(z) = (z>0) ? ONE : 0.
  - Sigmoid uses the PLAN approximation on a = |z|:
    - a ≥ 5 → ONE.
    - 2.375 ≤ a < 5 → a/32 + 0.84375.
    - 1 ≤ a < 2.375 → a/8 + 0.625.
    - a < 1 → a/4 + 0.5.
    - For z < 0, result = ONE − f(a).
    - Divisions are arithmetic shifts.
  - act'(z) for Sigmoid = p*(ONE−p), where p = prediction.
- Gradient (combinational):
  - g = sum_k(next_layer_weights[k]*error_gradient_next_layer[k]).
  - error_gradient = g * act'(z_q), with act' evaluated on the registered z_q and prediction.
  - `activation` is sampled live, so it must be held stable during training.
- Update, at a non-reset posedge with training=1:
  - w_i <= w_i − lr*error_gradient*x_q_i.
  - bias <= bias − lr*error_gradient.
  - Products are evaluated left-to-right: (lr*delta)*x.
  - Occurs on the same edge as the forward register update; the forward path uses pre-update weights.
- training=0: weights and bias hold; the forward path keeps running.
- current_weights is a direct view of the w_i registers. Bias is internal.
- Reset asserted mid-training discards state immediately at that edge.

Test Plan:
- Reset and hold: rst=1 for 2 cycles, then values={ONE,ONE}, activation=Linear, training=0. After reset, current_weights={0x8000,0x8000} and prediction=0; one cycle later prediction=0x0001_0000; held values keep prediction constant.
- Sigmoid points, training=0: values={0,0} → prediction 0x8000. values={ONE,ONE} (z=1.0) → 0xC000. values={−4·ONE,−4·ONE} (z=−4) → ONE − (0.125+0.84375) = 0x0000_0800.
- Linear SGD step: values={ONE,0}, next_layer_weights={ONE}, error_gradient_next_layer={HALF}, lr=ONE, training=1, after reset plus one cycle. Expect error_gradient=0x8000; next edge w0=0, w1=0x8000, bias=−0x8000. The following prediction reflects the new weights: z = 0 − 0.5 = −0x8000.
- ReLU dead zone: force z<0 (values={−ONE,−ONE}) → prediction=0, error_gradient=0, weights unchanged despite training=1.
- Saturation: values={0x7FFF_FFFF,0x7FFF_FFFF}, Linear → prediction=0x7FFF_FFFF (no wrap).
- Reset mid-training: assert rst during an update cycle → weights return to INIT_WEIGHT at that edge and no update is applied.
